// File: rtl/mm_line_responder_pkg.sv
// Shared constants for the main-memory line responder: line geometry and FSM encodings.
package mm_line_responder_pkg;

  localparam int unsigned LINE_BITS        = 256;
  localparam int unsigned LINE_OFFSET_BITS = 5;

  localparam logic [1:0] MM_IDLE    = 2'd0;
  localparam logic [1:0] MM_RD_WAIT = 2'd1;
  localparam logic [1:0] MM_WR_WAIT = 2'd2;

endpackage

// File: rtl/mm_line_responder_line_array.sv
// mm_line_array: single-port synchronous line RAM with write enable and registered read.
// Contents are never reset; only the read register clears on reset.
module mm_line_array
  import mm_line_responder_pkg::*;
#(
  parameter int unsigned LINE_IDX_BITS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic                     re,
  input  logic [LINE_IDX_BITS-1:0] addr,
  input  logic [LINE_BITS-1:0]     wd,
  output logic [LINE_BITS-1:0]     rd
);

  logic [LINE_BITS-1:0] mem_q [2**LINE_IDX_BITS];
  logic [LINE_BITS-1:0] rd_q;
  logic [LINE_BITS-1:0] rd_d;

  always_comb begin
    rd_d = rd_q;
    if (re) rd_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wd;
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign rd = rd_q;

endmodule

// File: rtl/mm_line_responder.sv
// Main-memory end of the cache line-fill/eviction interface with fixed read/write latency.
// Optional protocol checking is enabled by defining MM_PROTO_CHECK_EN.
module mm_line_responder #(
  parameter int unsigned LINE_IDX_BITS = 10,
  parameter int unsigned LINE_BITS     = 256,
  parameter int unsigned RD_LATENCY    = 4,
  parameter int unsigned WR_LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          mm_a,
  input  logic                 mm_read,
  input  logic                 mm_write,
  input  logic [LINE_BITS-1:0] mm_wd,
  output logic [LINE_BITS-1:0] mm_rd,
  output logic                 mm_valid,
  output logic                 mm_busy,
  output logic                 mm_wr_done,
  output logic                 mm_proto_err
);

  import mm_line_responder_pkg::LINE_OFFSET_BITS;
  import mm_line_responder_pkg::MM_IDLE;
  import mm_line_responder_pkg::MM_RD_WAIT;
  import mm_line_responder_pkg::MM_WR_WAIT;

  localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);
  localparam bit RD_ONE = (RD_LATENCY == 1);
  localparam bit WR_ONE = (WR_LATENCY == 1);

  logic [1:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [LINE_IDX_BITS-1:0] idx_q, idx_d;
  logic [LINE_BITS-1:0]     wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;
  logic                     wr_done_q, wr_done_d;

  logic [LINE_IDX_BITS-1:0] idx_in;
  logic [LINE_IDX_BITS-1:0] ram_addr;
  logic                     ram_we;
  logic                     ram_re;
  logic                     unused_a_bits;

  assign idx_in        = mm_a[LINE_IDX_BITS+LINE_OFFSET_BITS-1 -: LINE_IDX_BITS];
  assign unused_a_bits = ^{mm_a[31:LINE_IDX_BITS+LINE_OFFSET_BITS], mm_a[LINE_OFFSET_BITS-1:0]};

  // The RAM read is issued one cycle ahead of the completion cycle so that
  // mm_rd is already loaded when mm_valid is high; strobes are registered the same way.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    valid_d   = 1'b0;
    wr_done_d = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      MM_IDLE: begin
        if (mm_write) begin
          state_d   = MM_WR_WAIT;
          cnt_d     = WR_LOAD;
          idx_d     = idx_in;
          wdata_d   = mm_wd;
          wr_done_d = WR_ONE;
        end else if (mm_read) begin
          state_d = MM_RD_WAIT;
          cnt_d   = RD_LOAD;
          idx_d   = idx_in;
          valid_d = RD_ONE;
          ram_re  = RD_ONE;
        end
      end
      MM_RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          valid_d = 1'b1;
          ram_re  = 1'b1;
        end
        if (cnt_q == 4'd0) begin
          state_d = MM_IDLE;
          cnt_d   = '0;
        end
      end
      MM_WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) wr_done_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = MM_IDLE;
          cnt_d   = '0;
          ram_we  = ~reset;
        end
      end
      default: begin
        state_d = MM_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d   = (state_d != MM_IDLE);
    ram_addr = (state_q == MM_IDLE) ? idx_in : idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MM_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      wr_done_q <= wr_done_d;
    end
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  mm_line_array #(
    .LINE_IDX_BITS(LINE_IDX_BITS)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wd   (wdata_q),
    .rd   (mm_rd)
  );

  assign mm_valid   = valid_q;
  assign mm_busy    = busy_q;
  assign mm_wr_done = wr_done_q;

`ifdef MM_PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;
  logic ev_busy, ev_both, ev_align;

  always_comb begin
    ev_busy     = (mm_read | mm_write) & busy_q;
    ev_both     = mm_read & mm_write;
    ev_align    = (mm_read | mm_write) & (mm_a[LINE_OFFSET_BITS-1:0] != '0);
    proto_err_d = proto_err_q | ev_busy | ev_both | ev_align;
  end

  always_ff @(posedge clk) begin
    if (reset) proto_err_q <= 1'b0;
    else       proto_err_q <= proto_err_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ev_busy)  $display("%0t mm_line_responder: protocol error, command while busy", $time);
      if (ev_both)  $display("%0t mm_line_responder: protocol error, read and write together", $time);
      if (ev_align) $display("%0t mm_line_responder: protocol error, unaligned line address", $time);
    end
  end
`endif

  assign mm_proto_err = proto_err_q;
`else
  assign mm_proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mm_line_responder.sv
// Directed bench for mm_line_responder: vector table of line commands plus corner-case sequences.
module tb_mm_line_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  mm_a;
  logic         mm_read;
  logic         mm_write;
  logic [255:0] mm_wd;
  logic [255:0] mm_rd;
  logic         mm_valid;
  logic         mm_busy;
  logic         mm_wr_done;
  logic         mm_proto_err;

  int n_chk  = 0;
  int n_fail = 0;

  mm_line_responder #(
    .LINE_IDX_BITS(10),
    .LINE_BITS    (256),
    .RD_LATENCY   (RD_LAT),
    .WR_LATENCY   (WR_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mm_a        (mm_a),
    .mm_read     (mm_read),
    .mm_write    (mm_write),
    .mm_wd       (mm_wd),
    .mm_rd       (mm_rd),
    .mm_valid    (mm_valid),
    .mm_busy     (mm_busy),
    .mm_wr_done  (mm_wr_done),
    .mm_proto_err(mm_proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [31:0]  a;
    logic [255:0] wd;
    logic [255:0] exp_rd;
  } vec_t;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Issues one command in the current cycle and checks every cycle up to the one after completion.
  task automatic do_cmd(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [255:0] wd, input logic [255:0] exp_rd);
    int lat;
    mm_a     = a;
    mm_write = wr;
    mm_read  = rd;
    mm_wd    = wd;
    lat      = wr ? WR_LAT : RD_LAT;
    for (int c = 1; c <= lat + 1; c++) begin
      step();
      if (c == 1) begin
        mm_write = 1'b0;
        mm_read  = 1'b0;
      end
      chk($sformatf("busy a=%h c=%0d", a, c), 256'(mm_busy), 256'(c <= lat));
      chk($sformatf("valid a=%h c=%0d", a, c), 256'(mm_valid), 256'(!wr && c == lat));
      chk($sformatf("wr_done a=%h c=%0d", a, c), 256'(mm_wr_done), 256'(wr && c == lat));
      if (!wr && c >= lat) chk($sformatf("rd a=%h c=%0d", a, c), mm_rd, exp_rd);
    end
  endtask

  logic [255:0] d_a5, d_alias, d_pat, d_ones, d_new;
  vec_t vecs [10];

  initial begin
    d_a5    = {8{32'hA5A5_0001}};
    d_alias = {8{32'h8040_BEEF}};
    d_pat   = {4{64'h0123_4567_89AB_CDEF}};
    d_ones  = '1;
    d_new   = {8{32'h0BAD_F00D}};

    vecs[0] = '{1, 0, 32'h0000_0040, d_a5,    '0};
    vecs[1] = '{0, 1, 32'h0000_0040, '0,      d_a5};
    vecs[2] = '{1, 0, 32'h0000_8040, d_alias, '0};
    vecs[3] = '{0, 1, 32'h0000_0040, '0,      d_alias};
    vecs[4] = '{1, 0, 32'h0000_0060, d_pat,   '0};
    vecs[5] = '{0, 1, 32'h0000_0060, '0,      d_pat};
    vecs[6] = '{0, 1, 32'h0000_8040, '0,      d_alias};
    vecs[7] = '{1, 0, 32'h0000_7FE0, d_ones,  '0};
    vecs[8] = '{0, 1, 32'h0000_7FE0, '0,      d_ones};
    vecs[9] = '{0, 1, 32'hFFFF_8040, '0,      d_alias};

    reset    = 1'b1;
    mm_a     = '0;
    mm_read  = 1'b0;
    mm_write = 1'b0;
    mm_wd    = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("reset valid", 256'(mm_valid), 256'(0));
    chk("reset busy", 256'(mm_busy), 256'(0));
    chk("reset wr_done", 256'(mm_wr_done), 256'(0));
    chk("reset rd", mm_rd, '0);
    chk("reset proto_err", 256'(mm_proto_err), 256'(0));

    for (int i = 0; i < 10; i++)
      do_cmd(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd, vecs[i].exp_rd);

    // Read of 0x60 with a stray read pulse at T+2; only one strobe, data from 0x60.
    mm_a    = 32'h0000_0060;
    mm_read = 1'b1;
    for (int c = 1; c <= RD_LAT + 2; c++) begin
      step();
      mm_read = (c == 2);
      mm_a    = (c == 2) ? 32'h0000_0040 : 32'h0000_0060;
      chk($sformatf("ign valid c=%0d", c), 256'(mm_valid), 256'(c == RD_LAT));
      chk($sformatf("ign busy c=%0d", c), 256'(mm_busy), 256'(c <= RD_LAT));
      if (c == RD_LAT) chk("ign rd", mm_rd, d_pat);
`ifdef MM_PROTO_CHECK_EN
      chk($sformatf("ign proto_err c=%0d", c), 256'(mm_proto_err), 256'(c >= 3));
`else
      chk($sformatf("ign proto_err c=%0d", c), 256'(mm_proto_err), 256'(0));
`endif
    end

    // Simultaneous read and write: write wins.
    do_cmd(1, 1, 32'h0000_0080, 256'h1, '0);
    do_cmd(0, 1, 32'h0000_0080, '0, 256'h1);
    // Offset bits ignored.
    do_cmd(0, 1, 32'h0000_009F, '0, 256'h1);

    // Reset mid-read at T+2.
    mm_a    = 32'h0000_0080;
    mm_read = 1'b1;
    step();
    mm_read = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstrd busy", 256'(mm_busy), 256'(0));
    chk("rstrd valid", 256'(mm_valid), 256'(0));
    chk("rstrd rd", mm_rd, '0);
    for (int c = 4; c <= 6; c++) begin
      step();
      chk($sformatf("rstrd valid c=%0d", c), 256'(mm_valid), 256'(0));
    end
    do_cmd(0, 1, 32'h0000_0080, '0, 256'h1);

    // Reset at T+1 of a write: commit must not happen.
    mm_a     = 32'h0000_0040;
    mm_wd    = d_new;
    mm_write = 1'b1;
    step();
    mm_write = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    chk("rstwr wr_done", 256'(mm_wr_done), 256'(0));
    chk("rstwr busy", 256'(mm_busy), 256'(0));
    step();
    do_cmd(0, 1, 32'h0000_0040, '0, d_alias);

`ifndef MM_PROTO_CHECK_EN
    chk("final proto_err", 256'(mm_proto_err), 256'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_line_responder.md
Name: mm_line_responder

Overview:
- Main-memory end of the cache line-fill/eviction interface.
- Accepts single-cycle mm_read / mm_write line commands from the cache.
- Stores 256-bit lines in an internal line array and returns fill data with a fixed, parameterised latency.
- Replaces the testbench stub on the mm_* side. Used in simulation and on FPGA as the backing store behind the L1.

Parameters:
- LINE_IDX_BITS, 10, number of line-index bits in the backing array (2**LINE_IDX_BITS lines of 32B).
- LINE_BITS, 256, line width in bits; fixed at 256 for this interface.
- RD_LATENCY, 4, cycles from the read accept cycle to the mm_valid pulse; legal range 1..15.
- WR_LATENCY, 2, cycles from the write accept cycle to array update and mm_wr_done; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- mm_a  input  32  line address from cache; bits [4:0] ignored; line index = mm_a[LINE_IDX_BITS+4:5]; upper bits ignored (aliasing).
- mm_read  input  1  line-fill command, one-cycle pulse.
- mm_write  input  1  line-eviction command, one-cycle pulse.
- mm_wd  input  256  eviction data, sampled with mm_write.
- mm_rd  output  256  fill data, valid when mm_valid=1.
- mm_valid  output  1  one-cycle fill-data strobe.
- mm_busy  output  1  high while a command is in flight; commands are ignored while high.
- mm_wr_done  output  1  one-cycle pulse when an eviction has been committed to the array.
- mm_proto_err  output  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high):
  - mm_valid=0, mm_busy=0, mm_wr_done=0, mm_rd=0, mm_proto_err=0.
  - FSM goes to IDLE and the latency counter clears.
  - Array contents are NOT reset.
- Reset asserted mid-operation aborts the command: no mm_valid, no mm_wr_done. A pending write that has not yet reached its commit cycle is not written.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE:
  - mm_read=1 with mm_write=0 (accept cycle T): latch the line index; go to RD_WAIT; counter=RD_LATENCY-1.
  - mm_write=1 (accept cycle T): latch index and mm_wd; go to WR_WAIT; counter=WR_LATENCY-1.
  - mm_read=1 and mm_write=1 together: write wins, read is dropped.
- mm_busy is registered: 1 from T+1 through the completion cycle inclusive, 0 in IDLE.
- RD_WAIT: counter decrements each cycle. In the cycle after it reaches 0 (cycle T+RD_LATENCY):
  - mm_rd <= array[idx] and mm_valid=1 for exactly that cycle;
  - return to IDLE.
  - mm_rd holds its last value afterwards.
- WR_WAIT: at T+WR_LATENCY, array[idx] <= latched data, mm_wr_done=1 for one cycle, return to IDLE.
- Back-to-back commands: a new command can be accepted in the cycle mm_busy deasserts, giving a minimum spacing of latency+1 cycles between accepts.
- Read after write to the same line returns the new data; the write commits before the next accept is possible.
- Counter width is 4 bits; no wrap, since counter loads are bounded by the latency range.
- Commands arriving while mm_busy=1 are ignored, with no queueing.

Optional Feature:
- Macro: MM_PROTO_CHECK_EN.
- Defined: mm_proto_err is set and held until reset on any of:
  - a command asserted while mm_busy=1;
  - mm_read and mm_write asserted in the same cycle;
  - mm_a[4:0] != 0 on a command.
  Under simulation, each such event also prints a $display with the time and cause.
- Undefined: no checking logic; mm_proto_err is tied to 0.

Decomposition:
- Shared package/header holds:
  - localparams LINE_BITS=256 and LINE_OFFSET_BITS=5;
  - FSM state encodings MM_IDLE=2'd0, MM_RD_WAIT=2'd1, MM_WR_WAIT=2'd2.
- One sub-module: mm_line_array. It is a single-port synchronous line RAM (2**LINE_IDX_BITS x 256) with write enable and registered read, instantiated once.
- FSM and counter stay in the top module.

Test Plan:
- Reset, then write line: mm_write with mm_a=32'h0000_0040, mm_wd={8{32'hA5A5_0001}} at cycle T.
  - Required: mm_busy=1 at T+1..T+2; mm_wr_done=1 at T+2 only.
- Read back the same line: mm_read with mm_a=32'h0000_0040 at cycle T.
  - Required: mm_valid=1 at T+4 only; mm_rd={8{32'hA5A5_0001}}; mm_busy=0 at T+5.
- Aliasing: write to 32'h0000_8040 with LINE_IDX_BITS=10, then read 32'h0000_0040.
  - Required: the read returns the 8040 data.
- Ignored command: mm_read pulse at T+2 during a busy read.
  - Required: exactly one mm_valid, at T+4; with MM_PROTO_CHECK_EN, mm_proto_err=1 from T+3.
- Simultaneous command: mm_read=mm_write=1 with mm_wd=256'h1.
  - Required: mm_wr_done pulse, no mm_valid; the following read returns 256'h1.
- Reset mid-read: reset asserted at T+2 of a read.
  - Required: mm_valid never pulses, mm_busy=0 at T+3, and the array is unchanged on re-read.
